// File: rtl/kgp_alu.sv
// -----------------------------------------------------------------------------
// kgp_alu -- registered integer ALU for the KGPminiRISC datapath.
//
// Operands and the operation code are captured on a rising clk edge when
// in_valid is high. The result and status flags are registered, so they
// appear one cycle later, qualified by out_valid.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a, b and alu_cntrl are valid this cycle
//   a          in   operand A
//   b          in   operand B; its low log2(WIDTH) bits are the shift amount
//   alu_cntrl  in   operation select (see OP_* constants)
//   result     out  registered operation result
//   flag       out  registered status: [2]=carry/borrow, [1]=zero, [0]=sign
//   out_valid  out  result/flag were updated by the previous cycle's issue
// -----------------------------------------------------------------------------
module kgp_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_cntrl,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flag,
  output logic             out_valid
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_COMP = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_DIFF = 4'b1000;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_reserved;
  logic [2:0]       w_flag;

  // Shifts look only at the low bits of b, so a shift by WIDTH wraps to 0.
  assign w_shamt = b[SHW-1:0];
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_xor   = a ^ b;

  // Index of the lowest differing bit. Scanning from the top down lets the
  // last hit (the lowest set bit) win; no difference at all yields WIDTH.
  always_comb begin
    w_diff = WIDTH'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_xor[i]) w_diff = WIDTH'(i);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latch).
    w_res      = '0;
    w_carry    = 1'b0;
    w_reserved = 1'b0;
    case (alu_cntrl)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res   = a - b;
        w_carry = (a < b);
      end
      OP_AND:  w_res = a & b;
      OP_XOR:  w_res = w_xor;
      OP_COMP: begin
        w_res   = '0 - b;
        w_carry = |b;
      end
      OP_SLL:  w_res = a << w_shamt;
      OP_SRL:  w_res = a >> w_shamt;
      OP_SRA:  w_res = $unsigned($signed(a) >>> w_shamt);
      OP_DIFF: w_res = w_diff;
      default: w_reserved = 1'b1;
    endcase
  end

  // Reserved codes clear every flag, including zero, even though the
  // result itself is 0.
  assign w_flag = w_reserved ? 3'b000
                             : {w_carry, (w_res == '0), w_res[WIDTH-1]};

  // NOTE: sequential state is written with non-blocking assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flag      <= 3'b000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= w_res;
        flag   <= w_flag;
      end
    end
  end

endmodule

// File: tb/tb_kgp_alu.sv
// -----------------------------------------------------------------------------
// tb_kgp_alu -- self-checking bench for kgp_alu: directed cases followed by
// randomized traffic checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_kgp_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_cntrl;
  logic [31:0] result;
  logic [2:0]  flag;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  kgp_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_cntrl (alu_cntrl),
    .result    (result),
    .flag      (flag),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {flag, result}, from the operation definitions.
  function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    longint unsigned s;
    logic [31:0] r;
    logic [31:0] d;
    logic        c;
    int          sh;
    int          n;
    sh = int'(y % 32);
    c  = 1'b0;
    r  = 32'd0;
    case (op)
      4'd0: begin s = longint'(x) + longint'(y); r = s[31:0]; c = s[32]; end
      4'd1: begin r = x - y; c = (x < y); end
      4'd2: r = x & y;
      4'd3: r = x ^ y;
      4'd4: begin r = 32'd0 - y; c = (y != 0); end
      4'd5: r = x << sh;
      4'd6: r = x >> sh;
      4'd7: r = x[31] ? ((x >> sh) | ~(32'hFFFF_FFFF >> sh)) : (x >> sh);
      4'd8: begin
        d = x ^ y;
        if (d == 0) r = 32;
        else begin
          n = 0;
          while (d[0] == 1'b0) begin d = d >> 1; n++; end
          r = n;
        end
      end
      default: return 35'd0;
    endcase
    return {c, (r == 0), r[31], r};
  endfunction

  // Issue one operation and check it one cycle later.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] er, input logic [2:0] ef);
    @(negedge clk);
    in_valid = 1'b1; alu_cntrl = op; a = x; b = y;
    @(posedge clk); #1;
    check({tag, "_res"}, result, er);
    check({tag, "_flag"}, 32'(flag), 32'(ef));
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  logic [34:0] exp_m;
  logic [31:0] exp_r;
  logic [2:0]  exp_f;
  logic        exp_v;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; alu_cntrl = 4'd0; a = 32'd4; b = 32'd1;
    #3;
    check("rst_res", result, 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_vld", 32'(out_valid), 32'd0);
    check("rst_hold_res", result, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;

    do_op("add00", 4'd0, 32'd0, 32'd0, 32'd0, 3'b010);
    do_op("rsvd", 4'd15, 32'd5, 32'd5, 32'd0, 3'b000);
    do_op("add41", 4'd0, 32'd4, 32'd1, 32'd5, 3'b000);
    do_op("addwrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'b110);
    do_op("sub31", 4'd1, 32'd3, 32'd1, 32'd2, 3'b000);
    do_op("sub13", 4'd1, 32'd1, 32'd3, 32'hFFFF_FFFE, 3'b101);
    do_op("comp1", 4'd4, 32'd0, 32'd1, 32'hFFFF_FFFF, 3'b101);
    do_op("comp0", 4'd4, 32'd9, 32'd0, 32'd0, 3'b010);
    do_op("and", 4'd2, 32'd3, 32'd3, 32'd3, 3'b000);
    do_op("xor", 4'd3, 32'd3, 32'd3, 32'd0, 3'b010);
    do_op("sll", 4'd5, 32'd7, 32'd1, 32'd14, 3'b000);
    do_op("srl", 4'd6, 32'd3, 32'd1, 32'd1, 3'b000);
    do_op("sra", 4'd7, 32'd11, 32'd1, 32'd5, 3'b000);
    do_op("sraneg", 4'd7, 32'h8000_0000, 32'd1, 32'hC000_0000, 3'b001);
    do_op("sll33", 4'd5, 32'd1, 32'd33, 32'd2, 3'b000);
    do_op("diff", 4'd8, 32'd11, 32'd33, 32'd1, 3'b000);
    do_op("diffeq", 4'd8, 32'd7, 32'd7, 32'd32, 3'b000);
    do_op("diff31", 4'd8, 32'd0, 32'h8000_0000, 32'd31, 3'b000);

    // Back-to-back issue, then an idle cycle that must hold the last result.
    do_op("b2b0", 4'd0, 32'd1, 32'd1, 32'd2, 3'b000);
    do_op("b2b1", 4'd3, 32'd5, 32'd1, 32'd4, 3'b000);
    do_op("b2b2", 4'd6, 32'd8, 32'd3, 32'd1, 3'b000);
    @(negedge clk);
    in_valid = 1'b0; a = 32'hDEAD_BEEF; alu_cntrl = 4'd0;
    @(posedge clk); #1;
    check("idle_vld", 32'(out_valid), 32'd0);
    check("idle_res", result, 32'd1);

    // Reset mid-operation discards the in-flight result.
    @(negedge clk);
    in_valid = 1'b1; alu_cntrl = 4'd0; a = 32'd10; b = 32'd20;
    @(posedge clk); #1;
    check("pre_rst_res", result, 32'd30);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_res", result, 32'd0);
    check("midrst_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("postrst_vld", 32'(out_valid), 32'd0);
    check("postrst_res", result, 32'd0);

    // Randomized traffic against the model.
    exp_r = 32'd0; exp_f = 3'b000;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 8);
      alu_cntrl = 4'($urandom_range(0, 15));
      a         = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 63));
        2:       b = a ^ (32'd1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      exp_v = in_valid;
      if (in_valid) begin
        exp_m = model(alu_cntrl, a, b);
        exp_r = exp_m[31:0];
        exp_f = exp_m[34:32];
      end
      @(posedge clk); #1;
      check("rnd_res", result, exp_r);
      check("rnd_flag", 32'(flag), 32'(exp_f));
      check("rnd_vld", 32'(out_valid), 32'(exp_v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
